adc_conv_seq: RTL

Sequencer for the external parallel ADC on the RRAM read path. It drives one complete conversion per request: ADC_CONVST pulse, wait for ADC_EOC, ADC_RD strobe, data latch. It sits between the top-level test FSM, which issues `start` once the mux, RRAM and DAC settings are stable, and the ADC pins. It also owns ADC_PD and the end-of-conversion timeout.

---
 rtl/adc_conv_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/adc_conv_seq.sv
// adc_conv_seq: one ADC conversion per start (CONVST pulse, wait EOC,
// RD strobe, latch). Optional macro: ADC_AUTO_PD_EN (ADC power-down control).
// Ports: clk_10MHz, reset (sync, active-high), locked, start, ADC_EOC (async,
//   active-low), adc_data -> ADC_CONVST, ADC_RD (active-low), ADC_PD,
//   busy, sample, sample_valid, timeout.
`timescale 1ns/1ps
module adc_conv_seq #(
  parameter int DATA_W       = 12,
  parameter int CONVST_LOW   = 2,
  parameter int RD_LOW       = 3,
  parameter int CONV_TIMEOUT = 100,
  parameter int WAKE_CYCLES  = 20
) (
  input  logic              clk_10MHz,
  input  logic              reset,
  input  logic              locked,
  input  logic              start,
  input  logic              ADC_EOC,
  input  logic [DATA_W-1:0] adc_data,
  output logic              ADC_CONVST,
  output logic              ADC_RD,
  output logic              ADC_PD,
  output logic              busy,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              timeout
);

  typedef enum logic [2:0] {
    IDLE, WAKE, CONV, WAIT_EOC, READ, DONE
  } state_t;

  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] CONV_LAST = 8'(CONVST_LOW - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LOW - 1);
  localparam logic [7:0] TO_LAST   = 8'(CONV_TIMEOUT - 1);

`ifdef ADC_AUTO_PD_EN
  localparam logic PD_IDLE = 1'b1;
`else
  localparam logic PD_IDLE = 1'b0;
`endif

  state_t     state, next_state;
  logic [7:0] cnt;
  logic       eoc_q1, eoc_s;
  logic       to_hit, latch;
  logic       convst_d, rd_d, pd_d, busy_d;

  // state register, EOC synchronizer, per-state counter
  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      eoc_q1 <= 1'b1;
      eoc_s  <= 1'b1;
    end else begin
      state  <= next_state;
      eoc_q1 <= ADC_EOC;
      eoc_s  <= eoc_q1;
      if (next_state != state)
        cnt <= '0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  // next state; loss of lock overrides everything
  always_comb begin
    next_state = state;
    to_hit     = 1'b0;
    latch      = 1'b0;
    if (!locked) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // busy is still high in the timeout-pulse cycle
          if (start && !busy)
`ifdef ADC_AUTO_PD_EN
            next_state = WAKE;
`else
            next_state = CONV;
`endif
        end
        WAKE:
          if (cnt == WAKE_LAST) next_state = CONV;
        CONV:
          if (cnt == CONV_LAST) next_state = WAIT_EOC;
        WAIT_EOC: begin
          // EOC has priority over an expiring timeout
          if (!eoc_s) begin
            next_state = READ;
          end else if (cnt == TO_LAST) begin
            next_state = IDLE;
            to_hit     = 1'b1;
          end
        end
        READ: begin
          if (cnt == RD_LAST) begin
            next_state = DONE;
            latch      = 1'b1;
          end
        end
        DONE:
          next_state = IDLE;
        default:
          next_state = IDLE;
      endcase
    end
  end

  // output levels for the coming state
  always_comb begin
    convst_d = (next_state != CONV);
    rd_d     = (next_state != READ);
    busy_d   = (next_state != IDLE) || to_hit;
`ifdef ADC_AUTO_PD_EN
    pd_d     = (next_state == IDLE);
`else
    pd_d     = 1'b0;
`endif
  end

  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      ADC_CONVST   <= 1'b1;
      ADC_RD       <= 1'b1;
      ADC_PD       <= PD_IDLE;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      ADC_CONVST   <= convst_d;
      ADC_RD       <= rd_d;
      ADC_PD       <= pd_d;
      busy         <= busy_d;
      sample_valid <= latch;
      timeout      <= to_hit;
      if (latch)
        sample <= adc_data;
    end
  end

endmodule
